reg_file_mp: RTL
================

# reg_file_mp

Parametrised, clocked successor to the single-cycle MIPS register file. Holds `2**ADDR_W` general-purpose registers of `DATA_W` bits. Provides `NUM_RD` asynchronous read ports and one synchronous write port with byte enables. Register 0 is hardwired to zero, and all registers clear on reset. Sits between the decode stage (read addresses) and the writeback mux (write data), for both the single-cycle datapath and the planned pipelined core.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits; must be a multiple of 8.
- `ADDR_W`, 5: address width; depth = `2**ADDR_W`.
- `NUM_RD`, 2: number of read ports; valid range 1..4.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: reset; synchronous and active-high.
- `RA`, input, `NUM_RD*ADDR_W`: packed read addresses; port k is bits `[k*ADDR_W +: ADDR_W]`.
- `RD`, output, `NUM_RD*DATA_W`: packed read data; port k is bits `[k*DATA_W +: DATA_W]`.
- `WE`, input, 1: write enable.
- `WA`, input, `ADDR_W`: write address.
- `WD`, input, `DATA_W`: write data.
- `WBE`, input, `DATA_W/8`: byte write enables; bit i covers `WD[8i+7:8i]`.
- `wr_cnt`, output, 16: count of committed writes, for debug and coverage.

## Operation
- **Storage:** array of `2**ADDR_W` words of `DATA_W` bits.
- **Reset:** when `rst`=1 at a rising edge, every register is set to 0 and `wr_cnt` is set to 0. Reset overrides any simultaneous write.
- **Write commit:** a write commits at the rising edge when `WE`=1, `rst`=0, `WA`≠0 and `WBE`≠0.
  - Only the enabled bytes of `REG[WA]` take the corresponding bytes of `WD`.
  - Disabled bytes hold their previous value.
- **Register 0:** writes to address 0 are discarded. `REG[0]` always reads 0. `wr_cnt` does not increment for a discarded write.
- **Write counter:** `wr_cnt` increments by 1 per committed write and wraps from 0xFFFF to 0x0000.
- **Reads:** combinational. `RD[k] = REG[RA[k]]`, or 0 when `RA[k]`=0. Any number of ports may address the same register in the same cycle.
- **No write-first (macro absent):** a read of `WA` in the same cycle as a write returns the old contents. The new value is visible from the cycle after the edge.
- **Out-of-range addresses:** none exist; the depth is a full power of two.

## Timing
- Write latency: 1 clock. Data presented in cycle N is readable from cycle N+1. With bypass enabled, it is readable in cycle N.
- Read latency: 0 clocks, combinational from `RA` and register state.
- Reset values:
  - All registers: 0.
  - `RD` after reset: 0 on every port, regardless of `RA`.
  - `wr_cnt`: 0.
- Reset mid-operation: a write pending in the same cycle as `rst` is lost. The first write accepted after reset is the one in the first cycle with `rst`=0.
- No handshakes: the port is always ready, and one write per cycle is sustained indefinitely.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`.
- **Defined:** each read port forwards same-cycle write data.
  - Condition: `WE`=1, `WA`≠0, `RA[k]`=`WA`, `rst`=0.
  - Bytes with `WBE[i]`=1 return `WD`; bytes with `WBE[i]`=0 return the stored value.
  - This allows writeback and decode in the same cycle of a pipeline without a half-cycle clock.
- **Undefined:** no forwarding; reads return stored contents only. This is the default for the single-cycle core.

## Structure
- **Shared package `mips_pkg`:**
  - Constants `REG_ZERO` = 0 and `BYTE_W` = 8.
  - Typedef `reg_addr_t` (`ADDR_W` bits, default 5).
  - Typedef `word_t` (32 bits).
- **Sub-module `reg_file_rd_port`:** one instance per read port via a generate loop.
  - Inputs: address, array output, write-port signals.
  - Performs the array select, the zero override and the optional bypass merge.
- **Top level:** contains the storage array, byte-masked write logic and write counter.

## Test plan
- **Reset clear:** assert `rst` for 2 cycles after writing 0xDEADBEEF to r5 → `RD` of r5 = 0, `wr_cnt` = 0.
- **Full write and readback:** `WE`=1, `WA`=7, `WD`=0x12345678, `WBE`=0xF at edge N → port 0 reads 0x12345678 at N+1; port 1 on r7 also reads 0x12345678.
- **Byte enables:** r3 = 0xAABBCCDD, then write `WD`=0x11223344 with `WBE`=0x5 → r3 reads 0xAA22CC44.
- **Register 0:** write 0xFFFFFFFF to `WA`=0 → reads of r0 = 0, `wr_cnt` unchanged.
- **Same-cycle read of write address:** r9 = 0x1, then write 0x2 to r9 while `RA[0]`=9 → reads 0x1 without `REG_FILE_BYPASS_EN`, 0x2 with it.
- **Counter wrap and reset collision:** issue 65536 committed writes → `wr_cnt` = 0. Then `WE`=1 with `rst`=1 on the same edge → target register stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS datapath blocks
package mips_pkg;

  localparam int REG_ZERO   = 0;
  localparam int BYTE_W     = 8;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [31:0]           word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one combinational read port: array select, r0 override, optional bypass
// Forwarding of same-cycle write data is compiled in with REG_FILE_BYPASS_EN.
module reg_file_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]   ra,
  input  logic [DATA_W-1:0]   regs [2**ADDR_W],
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] wbe,
  output logic [DATA_W-1:0]   rd
);

  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] merged;

  assign stored = regs[ra];

`ifdef REG_FILE_BYPASS_EN
  logic hit;

  // Reset wins over the write, so a write seen during reset must not be forwarded.
  assign hit = we && !rst && (wa != ADDR_W'(REG_ZERO)) && (wa == ra);

  always_comb begin
    merged = stored;
    for (int i = 0; i < DATA_W / BYTE_W; i++) begin
      if (hit && wbe[i]) begin
        merged[i*BYTE_W +: BYTE_W] = wd[i*BYTE_W +: BYTE_W];
      end
    end
  end
`else
  logic unused_wr;

  assign unused_wr = ^{rst, we, wa, wd, wbe};
  assign merged    = stored;
`endif

  assign rd = (ra == ADDR_W'(REG_ZERO)) ? '0 : merged;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with byte-masked write port and write counter
// Same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WA,
  input  logic [DATA_W-1:0]        WD,
  input  logic [DATA_W/8-1:0]      WBE,
  output logic [15:0]              wr_cnt
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam int N_BYTES = DATA_W / BYTE_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  // r0 is only ever touched by reset, so it stays a constant zero.
  assign commit = WE && (WA != ADDR_W'(REG_ZERO)) && (WBE != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        regs[j] <= '0;
      end
      wr_cnt <= '0;
    end else if (commit) begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (WBE[i]) begin
          regs[WA][i*BYTE_W +: BYTE_W] <= WD[i*BYTE_W +: BYTE_W];
        end
      end
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .ra   (RA[k*ADDR_W +: ADDR_W]),
      .regs (regs),
      .rst  (rst),
      .we   (WE),
      .wa   (WA),
      .wd   (WD),
      .wbe  (WBE),
      .rd   (RD[k*DATA_W +: DATA_W])
    );
  end

endmodule
